// File: rtl/id_stage_hs_pkg.sv
// Shared decode constants for the RV32I ID stage: opcodes, ALU op/select encodings, default widths.
package id_stage_hs_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU op is {inst[30], funct3} for arithmetic; 4'b1111 is reserved for NOP.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    typedef enum logic [2:0] {
        SEL_NOP    = 3'd0,
        SEL_ARITH  = 3'd1,
        SEL_LUI    = 3'd2,
        SEL_AUIPC  = 3'd3,
        SEL_LINK   = 3'd4,
        SEL_LOAD   = 3'd5,
        SEL_STORE  = 3'd6,
        SEL_BRANCH = 3'd7
    } alu_sel_e;

endpackage

// File: rtl/id_decoder_comb.sv
// Pure combinational RV32I instruction-field decoder.
// ID_STAGE_ILLEGAL_TRAP_EN: flag unknown opcodes / bad funct3 as illegal (decoded as NOP).
module id_decoder_comb
    import id_stage_hs_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]             inst,
    output logic [3:0]              aluop,
    output logic [2:0]              alusel,
    output logic signed [XLEN-1:0]  imm,
    output logic                    use_rs1,
    output logic                    use_rs2,
    output logic                    rd_we,
    output logic                    is_load,
    output logic                    is_store,
    output logic                    is_jal,
    output logic                    illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

`ifdef ID_STAGE_ILLEGAL_TRAP_EN
    logic bad_class;
    always_comb begin
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP_IMM, OPC_OP: bad_class = 1'b0;
            OPC_JALR:   bad_class = (f3 != 3'b000);
            OPC_BRANCH: bad_class = (f3[2:1] == 2'b01);
            OPC_LOAD:   bad_class = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            OPC_STORE:  bad_class = f3[2] || (f3 == 3'b011);
            default:    bad_class = 1'b1;
        endcase
    end
    assign illegal = bad_class;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        aluop    = ALU_NOP;
        alusel   = SEL_NOP;
        imm      = '0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        rd_we    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_jal   = 1'b0;
        case (opc)
            OPC_LUI: begin
                aluop = ALU_ADD; alusel = SEL_LUI; imm = imm_u; rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                aluop = ALU_ADD; alusel = SEL_AUIPC; imm = imm_u; rd_we = 1'b1;
            end
            OPC_JAL: begin
                aluop = ALU_ADD; alusel = SEL_LINK; imm = imm_j; rd_we = 1'b1; is_jal = 1'b1;
            end
            OPC_JALR: begin
                aluop = ALU_ADD; alusel = SEL_LINK; imm = imm_i; rd_we = 1'b1; use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                aluop = ALU_SUB; alusel = SEL_BRANCH; imm = imm_b;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                aluop = ALU_ADD; alusel = SEL_LOAD; imm = imm_i;
                use_rs1 = 1'b1; rd_we = 1'b1; is_load = 1'b1;
            end
            OPC_STORE: begin
                aluop = ALU_ADD; alusel = SEL_STORE; imm = imm_s;
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only the shift-right pair distinguishes on inst[30]; elsewhere it is immediate data.
                aluop   = (f3 == 3'b101) ? {inst[30], f3} : {1'b0, f3};
                alusel  = SEL_ARITH; imm = imm_i; use_rs1 = 1'b1; rd_we = 1'b1;
            end
            OPC_OP: begin
                aluop   = {inst[30], f3};
                alusel  = SEL_ARITH; use_rs1 = 1'b1; use_rs2 = 1'b1; rd_we = 1'b1;
            end
            default: ;
        endcase
        if (illegal) begin
            aluop    = ALU_NOP;
            alusel   = SEL_NOP;
            imm      = '0;
            use_rs1  = 1'b0;
            use_rs2  = 1'b0;
            rd_we    = 1'b0;
            is_load  = 1'b0;
            is_store = 1'b0;
            is_jal   = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_hs.sv
// RV32I decode stage: handshake output register, load scoreboard, N-source forwarding, JAL redirect FSM.
// ID_STAGE_ILLEGAL_TRAP_EN (in id_decoder_comb) enables out_illegal_o; otherwise it stays 0.
module id_stage_hs
    import id_stage_hs_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int NUM_FW = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              inst_i,
    input  logic [XLEN-1:0]          pc_i,
    output logic [REG_AW-1:0]        rs1_addr_o,
    output logic [REG_AW-1:0]        rs2_addr_o,
    input  logic [XLEN-1:0]          rs1_data_i,
    input  logic [XLEN-1:0]          rs2_data_i,
    input  logic [NUM_FW-1:0]        fw_valid_i,
    input  logic [NUM_FW*REG_AW-1:0] fw_addr_i,
    input  logic [NUM_FW*XLEN-1:0]   fw_data_i,
    input  logic                     ld_done_i,
    input  logic [REG_AW-1:0]        ld_addr_i,
    input  logic [XLEN-1:0]          ld_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [3:0]               out_aluop_o,
    output logic [2:0]               out_alusel_o,
    output logic [2:0]               out_funct3_o,
    output logic [XLEN-1:0]          out_imm_o,
    output logic [XLEN-1:0]          out_op1_o,
    output logic [XLEN-1:0]          out_op2_o,
    output logic [REG_AW-1:0]        out_rd_o,
    output logic                     out_rd_we_o,
    output logic                     out_is_load_o,
    output logic                     out_is_store_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [XLEN-1:0]          out_jump_pc_o,
    output logic                     out_illegal_o,
    output logic                     redirect_o,
    output logic [XLEN-1:0]          redirect_pc_o
);

    localparam int NREG = 2**REG_AW;
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_REDIR = 1'b1;

    function automatic logic [XLEN-1:0] wrap_add(input logic [XLEN-1:0] a,
                                                 input logic signed [XLEN-1:0] b);
        return a + $unsigned(b);
    endfunction

    logic [3:0]             dec_aluop_p0;
    logic [2:0]             dec_alusel_p0;
    logic signed [XLEN-1:0] dec_imm_p0;
    logic                   dec_use_rs1_p0, dec_use_rs2_p0, dec_rd_we_p0;
    logic                   dec_is_load_p0, dec_is_store_p0, dec_is_jal_p0, dec_illegal_p0;
    logic [REG_AW-1:0]      rs1_p0, rs2_p0, rd_p0;
    logic [XLEN-1:0]        op1_p0, rs2_val_p0, op2_p0, jump_pc_p0;
    logic                   haz1_p0, haz2_p0, accept;

    logic [NREG-1:0]        busy;
    logic [0:0]             state;

    logic                   vld_p1, rd_we_p1, is_load_p1, is_store_p1, illegal_p1;
    logic [3:0]             aluop_p1;
    logic [2:0]             alusel_p1, funct3_p1;
    logic [XLEN-1:0]        imm_p1, op1_p1, op2_p1, pc_p1, jump_pc_p1;
    logic [REG_AW-1:0]      rd_p1;
    logic                   redir_p1;
    logic [XLEN-1:0]        redir_pc_p1;

    id_decoder_comb #(.XLEN(XLEN)) u_dec (
        .inst     (inst_i),
        .aluop    (dec_aluop_p0),
        .alusel   (dec_alusel_p0),
        .imm      (dec_imm_p0),
        .use_rs1  (dec_use_rs1_p0),
        .use_rs2  (dec_use_rs2_p0),
        .rd_we    (dec_rd_we_p0),
        .is_load  (dec_is_load_p0),
        .is_store (dec_is_store_p0),
        .is_jal   (dec_is_jal_p0),
        .illegal  (dec_illegal_p0)
    );

    // ---- stage p0: operand select, hazard detection, handshake ----
    assign rs1_p0     = inst_i[15 +: REG_AW];
    assign rs2_p0     = inst_i[20 +: REG_AW];
    assign rd_p0      = inst_i[7 +: REG_AW];
    assign rs1_addr_o = rs1_p0;
    assign rs2_addr_o = rs2_p0;
    assign jump_pc_p0 = wrap_add(pc_i, dec_imm_p0);

    always_comb begin
        op1_p0     = rs1_data_i;
        rs2_val_p0 = rs2_data_i;
        if (ld_done_i && ld_addr_i == rs1_p0) op1_p0     = ld_data_i;
        if (ld_done_i && ld_addr_i == rs2_p0) rs2_val_p0 = ld_data_i;
        // Walk oldest to youngest so the lowest index overrides last.
        for (int i = NUM_FW - 1; i >= 0; i--) begin
            if (fw_valid_i[i] && fw_addr_i[i*REG_AW +: REG_AW] == rs1_p0)
                op1_p0 = fw_data_i[i*XLEN +: XLEN];
            if (fw_valid_i[i] && fw_addr_i[i*REG_AW +: REG_AW] == rs2_p0)
                rs2_val_p0 = fw_data_i[i*XLEN +: XLEN];
        end
        if (rs1_p0 == '0) op1_p0     = '0;
        if (rs2_p0 == '0) rs2_val_p0 = '0;
        op2_p0 = dec_use_rs2_p0 ? rs2_val_p0 : $unsigned(dec_imm_p0);
    end

    // A register is unsafe if a load is in flight past EX, or the load sits in our own output register.
    assign haz1_p0 = dec_use_rs1_p0 && (rs1_p0 != '0) &&
                     ((busy[rs1_p0] && !(ld_done_i && ld_addr_i == rs1_p0)) ||
                      (vld_p1 && is_load_p1 && rd_p1 == rs1_p0));
    assign haz2_p0 = dec_use_rs2_p0 && (rs2_p0 != '0) &&
                     ((busy[rs2_p0] && !(ld_done_i && ld_addr_i == rs2_p0)) ||
                      (vld_p1 && is_load_p1 && rd_p1 == rs2_p0));

    assign in_ready_o = (!vld_p1 || out_ready_i) && !haz1_p0 && !haz2_p0 &&
                        (state == ST_RUN) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // Set after clear so a same-register set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (ld_done_i) busy[ld_addr_i] <= 1'b0;
            if (vld_p1 && out_ready_i && is_load_p1 && rd_p1 != '0) busy[rd_p1] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    // ---- stage p1: ID/EX output register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            aluop_p1    <= '0;
            alusel_p1   <= '0;
            funct3_p1   <= '0;
            imm_p1      <= '0;
            op1_p1      <= '0;
            op2_p1      <= '0;
            rd_p1       <= '0;
            rd_we_p1    <= 1'b0;
            is_load_p1  <= 1'b0;
            is_store_p1 <= 1'b0;
            pc_p1       <= '0;
            jump_pc_p1  <= '0;
            illegal_p1  <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1      <= 1'b1;
            aluop_p1    <= dec_aluop_p0;
            alusel_p1   <= dec_alusel_p0;
            funct3_p1   <= inst_i[14:12];
            imm_p1      <= $unsigned(dec_imm_p0);
            op1_p1      <= op1_p0;
            op2_p1      <= op2_p0;
            rd_p1       <= rd_p0;
            rd_we_p1    <= dec_rd_we_p0;
            is_load_p1  <= dec_is_load_p0;
            is_store_p1 <= dec_is_store_p0;
            pc_p1       <= pc_i;
            jump_pc_p1  <= jump_pc_p0;
            illegal_p1  <= dec_illegal_p0;
        end else if (out_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            redir_p1    <= 1'b0;
            redir_pc_p1 <= '0;
        end else if (flush_i || state == ST_REDIR) begin
            state    <= ST_RUN;
            redir_p1 <= 1'b0;
        end else if (accept && dec_is_jal_p0) begin
            state       <= ST_REDIR;
            redir_p1    <= 1'b1;
            redir_pc_p1 <= jump_pc_p0;
        end
    end

    assign out_valid_o    = vld_p1;
    assign out_aluop_o    = aluop_p1;
    assign out_alusel_o   = alusel_p1;
    assign out_funct3_o   = funct3_p1;
    assign out_imm_o      = imm_p1;
    assign out_op1_o      = op1_p1;
    assign out_op2_o      = op2_p1;
    assign out_rd_o       = rd_p1;
    assign out_rd_we_o    = rd_we_p1;
    assign out_is_load_o  = is_load_p1;
    assign out_is_store_o = is_store_p1;
    assign out_pc_o       = pc_p1;
    assign out_jump_pc_o  = jump_pc_p1;
    assign out_illegal_o  = illegal_p1;
    assign redirect_o     = redir_p1;
    assign redirect_pc_o  = redir_pc_p1;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: forwarding, x0, load-use, JAL redirect, backpressure/flush, reset.
module tb_id_stage_hs;
    import id_stage_hs_pkg::*;

    localparam int XLEN = 32, REG_AW = 5, NUM_FW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [31:0] inst_i;
    logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, ld_data_i;
    logic [REG_AW-1:0] rs1_addr_o, rs2_addr_o, ld_addr_i, out_rd_o;
    logic [NUM_FW-1:0] fw_valid_i;
    logic [NUM_FW*REG_AW-1:0] fw_addr_i;
    logic [NUM_FW*XLEN-1:0] fw_data_i;
    logic ld_done_i;
    logic [3:0] out_aluop_o;
    logic [2:0] out_alusel_o, out_funct3_o;
    logic [XLEN-1:0] out_imm_o, out_op1_o, out_op2_o, out_pc_o, out_jump_pc_o, redirect_pc_o;
    logic out_rd_we_o, out_is_load_o, out_is_store_o, out_illegal_o, redirect_o;

    id_stage_hs #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FW(NUM_FW)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .inst_i(inst_i), .pc_i(pc_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .fw_valid_i(fw_valid_i), .fw_addr_i(fw_addr_i), .fw_data_i(fw_data_i),
        .ld_done_i(ld_done_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_aluop_o(out_aluop_o), .out_alusel_o(out_alusel_o), .out_funct3_o(out_funct3_o),
        .out_imm_o(out_imm_o), .out_op1_o(out_op1_o), .out_op2_o(out_op2_o),
        .out_rd_o(out_rd_o), .out_rd_we_o(out_rd_we_o),
        .out_is_load_o(out_is_load_o), .out_is_store_o(out_is_store_o),
        .out_pc_o(out_pc_o), .out_jump_pc_o(out_jump_pc_o), .out_illegal_o(out_illegal_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    logic exp_illegal;

    initial begin
`ifdef ID_STAGE_ILLEGAL_TRAP_EN
        exp_illegal = 1'b1;
`else
        exp_illegal = 1'b0;
`endif
        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; inst_i = '0; pc_i = '0;
        rs1_data_i = '0; rs2_data_i = '0; fw_valid_i = '0; fw_addr_i = '0; fw_data_i = '0;
        ld_done_i = 1'b0; ld_addr_i = '0; ld_data_i = '0; out_ready_i = 1'b1;
        tick(); tick();
        check("rst_valid", out_valid_o, 0);
        check("rst_redirect", redirect_o, 0);
        check("rst_redirect_pc", redirect_pc_o, 0);
        check("rst_op1", out_op1_o, 0);
        rst_n = 1'b1;
        #1 check("rst_ready", in_ready_o, 1);

        // forwarding priority: fw0 > fw1 > load writeback > register file
        inst_i = enc_i(12'd1, 5'd3, 3'b000, 5'd4, OPC_OP_IMM);
        in_valid_i = 1'b1; rs1_data_i = 32'h5555;
        fw_valid_i = 2'b11; fw_addr_i = {5'd3, 5'd3}; fw_data_i = {32'hBBBB, 32'hAAAA};
        #1 check("fwd_rs1_addr", rs1_addr_o, 3);
        tick();
        check("fwd_valid", out_valid_o, 1);
        check("fwd_op1_fw0", out_op1_o, 32'hAAAA);
        check("fwd_op2_imm", out_op2_o, 1);
        check("fwd_rd", out_rd_o, 4);
        check("fwd_alusel", out_alusel_o, 32'(SEL_ARITH));
        fw_valid_i = 2'b10; ld_done_i = 1'b1; ld_addr_i = 5'd3; ld_data_i = 32'hCCCC;
        tick();
        check("fwd_op1_fw1", out_op1_o, 32'hBBBB);
        fw_valid_i = 2'b00;
        tick();
        check("fwd_op1_ld", out_op1_o, 32'hCCCC);
        ld_done_i = 1'b0;
        tick();
        check("fwd_op1_rf", out_op1_o, 32'h5555);

        // x0 always reads zero
        fw_valid_i = 2'b01; fw_addr_i = {5'd0, 5'd0}; fw_data_i = {32'h0, 32'hDEAD};
        rs1_data_i = 32'h1111; rs2_data_i = 32'h2222;
        inst_i = enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd2, OPC_OP);
        tick();
        check("x0_op1", out_op1_o, 0);
        check("x0_op2", out_op2_o, 0);
        fw_valid_i = 2'b00;

        // sign-extended immediate and SRAI aluop
        rs1_data_i = 32'h10;
        inst_i = enc_i(12'hFFF, 5'd1, 3'b000, 5'd8, OPC_OP_IMM);
        tick();
        check("neg_imm", out_imm_o, 32'hFFFF_FFFF);
        check("neg_op2", out_op2_o, 32'hFFFF_FFFF);
        inst_i = enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd8, OPC_OP_IMM);
        tick();
        check("srai_aluop", out_aluop_o, 4'b1101);

        // unknown opcode decodes to NOP
        inst_i = 32'h0000_0FFF;
        tick();
        check("nop_rd_we", out_rd_we_o, 0);
        check("nop_aluop", out_aluop_o, 4'b1111);
        check("nop_alusel", out_alusel_o, 32'(SEL_NOP));
        check("nop_illegal", out_illegal_o, exp_illegal);

        // load-use stall
        inst_i = enc_i(12'd0, 5'd1, 3'b010, 5'd5, OPC_LOAD); rs1_data_i = 32'h100;
        tick();
        check("lu_is_load", out_is_load_o, 1);
        inst_i = enc_r(7'd0, 5'd7, 5'd5, 3'b000, 5'd6, OPC_OP); rs2_data_i = 32'h77;
        #1 check("lu_stall_outreg", in_ready_o, 0);
        tick();
        check("lu_stall_busy", in_ready_o, 0);
        check("lu_bubble", out_valid_o, 0);
        tick();
        check("lu_stall_busy2", in_ready_o, 0);
        ld_done_i = 1'b1; ld_addr_i = 5'd5; ld_data_i = 32'h1234;
        #1 check("lu_release", in_ready_o, 1);
        tick();
        ld_done_i = 1'b0; in_valid_i = 1'b0;
        check("lu_valid", out_valid_o, 1);
        check("lu_op1", out_op1_o, 32'h1234);
        check("lu_op2", out_op2_o, 32'h77);
        check("lu_rd", out_rd_o, 6);

        // backpressure then flush; busy[9] from an older load survives
        inst_i = enc_i(12'd4, 5'd1, 3'b010, 5'd9, OPC_LOAD); in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        inst_i = enc_i(12'd5, 5'd2, 3'b000, 5'd10, OPC_OP_IMM); rs1_data_i = 32'h30;
        in_valid_i = 1'b1; out_ready_i = 1'b0;
        tick();
        check("bp_valid", out_valid_o, 1);
        inst_i = enc_r(7'd0, 5'd4, 5'd3, 3'b000, 5'd11, OPC_OP); rs1_data_i = 32'h99;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid", out_valid_o, 1);
            check("bp_hold_rd", out_rd_o, 10);
            check("bp_hold_op1", out_op1_o, 32'h30);
            check("bp_hold_imm", out_imm_o, 5);
            check("bp_ready", in_ready_o, 0);
        end
        flush_i = 1'b1; in_valid_i = 1'b0;
        tick();
        flush_i = 1'b0;
        check("flush_valid", out_valid_o, 0);
        out_ready_i = 1'b1;
        inst_i = enc_r(7'd0, 5'd0, 5'd9, 3'b000, 5'd12, OPC_OP); in_valid_i = 1'b1;
        #1 check("flush_busy_kept", in_ready_o, 0);
        ld_done_i = 1'b1; ld_addr_i = 5'd9;
        #1 check("flush_busy_clear", in_ready_o, 1);
        tick();
        ld_done_i = 1'b0; in_valid_i = 1'b0;
        check("flush_after_valid", out_valid_o, 1);

        // JAL redirect
        inst_i = 32'h0200_00EF; pc_i = 32'h100; in_valid_i = 1'b1;
        tick();
        inst_i = enc_i(12'd1, 5'd0, 3'b000, 5'd3, OPC_OP_IMM);
        check("jal_redirect", redirect_o, 1);
        check("jal_redirect_pc", redirect_pc_o, 32'h120);
        check("jal_jump_pc", out_jump_pc_o, 32'h120);
        check("jal_rd", out_rd_o, 1);
        #1 check("jal_stall", in_ready_o, 0);
        tick();
        in_valid_i = 1'b0;
        check("jal_pulse_end", redirect_o, 0);
        check("jal_run_ready", in_ready_o, 1);
        check("jal_no_accept", out_valid_o, 0);
        inst_i = 32'h0200_00EF; pc_i = 32'hFFFF_FFF0; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("jal_wrap_pc", redirect_pc_o, 32'h10);
        tick();
        pc_i = '0;

        // reset mid-stream clears output register and scoreboard
        inst_i = enc_i(12'd0, 5'd1, 3'b010, 5'd5, OPC_LOAD); in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        inst_i = enc_i(12'd1, 5'd1, 3'b000, 5'd4, OPC_OP_IMM); in_valid_i = 1'b1; out_ready_i = 1'b0;
        tick();
        in_valid_i = 1'b0;
        check("mrst_pre_valid", out_valid_o, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_valid", out_valid_o, 0);
        check("mrst_redirect", redirect_o, 0);
        check("mrst_rd", out_rd_o, 0);
        out_ready_i = 1'b1;
        inst_i = enc_r(7'd0, 5'd7, 5'd5, 3'b000, 5'd6, OPC_OP); in_valid_i = 1'b1;
        #1 check("mrst_no_stall", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
        check("mrst_issue", out_valid_o, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage_hs.md
Name: id_stage_hs

Overview:
- Next-generation instruction-decode stage for the RV32I pipeline.
- Decodes one instruction per cycle and holds the result in an internal ID/EX output register with valid/ready handshakes on both sides.
- Replaces the single last-load compare with a per-register load scoreboard plus an in-stage check, generalised to NUM_FW forwarding sources.
- Generates a registered JAL redirect through a two-state FSM.
- Sits between IF/ID and EX.

Parameters:
- XLEN, 32, data/address width.
- REG_AW, 5, register address width; register count is 2**REG_AW.
- NUM_FW, 2, number of forwarding sources; index 0 is the youngest and has the highest priority.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush_i  in  1  kill the stage (EX branch mispredict).
- in_valid_i  in  1  instruction valid from IF/ID.
- in_ready_o  out  1  stage accepts an instruction.
- inst_i  in  32  instruction.
- pc_i  in  XLEN  instruction pc.
- rs1_addr_o, rs2_addr_o  out  REG_AW  register-file read addresses (combinational from inst_i).
- rs1_data_i, rs2_data_i  in  XLEN  register-file data.
- fw_valid_i  in  NUM_FW  forward-source valid.
- fw_addr_i  in  NUM_FW*REG_AW  forward rd, packed.
- fw_data_i  in  NUM_FW*XLEN  forward data, packed.
- ld_done_i  in  1  load writeback this cycle.
- ld_addr_i  in  REG_AW  load rd.
- ld_data_i  in  XLEN  load data.
- out_valid_o  out  1  decoded entry valid.
- out_ready_i  in  1  EX accepts.
- out_aluop_o  out  4  ALU op.
- out_alusel_o  out  3  result select.
- out_funct3_o  out  3  funct3.
- out_imm_o  out  XLEN  immediate.
- out_op1_o  out  XLEN  rs1 value.
- out_op2_o  out  XLEN  rs2 value, or imm when the instruction has no rs2.
- out_rd_o  out  REG_AW  destination register.
- out_rd_we_o  out  1  destination write enable.
- out_is_load_o, out_is_store_o  out  1  memory-op flags.
- out_pc_o  out  XLEN  instruction pc.
- out_jump_pc_o  out  XLEN  pc+imm.
- out_illegal_o  out  1  see Optional Feature.
- redirect_o  out  1  JAL redirect pulse.
- redirect_pc_o  out  XLEN  JAL target.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all out_* registers 0, out_valid_o=0;
  - redirect_o=0, redirect_pc_o=0;
  - scoreboard cleared;
  - FSM=RUN.
- Decode classes:
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - SRLI/SRAI and OP set aluop[3]=inst[30].
  - Unknown opcode decodes to NOP: aluop/alusel NOP, rd_we=0.
- Operand select:
  - x0 always reads 0.
  - Otherwise priority order: fw[0] … fw[NUM_FW-1] (valid && addr match), then ld_done match, then register file.
- Scoreboard:
  - One busy bit per register; bit 0 is hard-wired 0.
  - Set busy[rd] when a load leaves the output register (out_valid_o && out_ready_i && out_is_load_o && rd≠0).
  - Clear on ld_done_i.
  - Same-register set and clear in the same cycle: set wins.
- Hazard, per used source register rs≠0:
  - (busy[rs] && !(ld_done_i && ld_addr_i==rs)), or
  - (out_valid_o && out_is_load_o && out_rd_o==rs).
- in_ready_o = (!out_valid_o || out_ready_i) && !hazard && FSM==RUN && !flush_i.
- Accept when in_valid_i && in_ready_o; the output register loads on the next edge (latency 1).
- If out_ready_i && !accept, out_valid_o clears.
- JAL FSM:
  - RUN → REDIR when a JAL is accepted; redirect_pc_o=pc_i+imm is registered.
  - REDIR: redirect_o=1 for exactly one cycle, in_ready_o=0, then back to RUN.
- flush_i:
  - next edge: out_valid_o=0, FSM=RUN, redirect_o=0;
  - scoreboard is untouched (older loads are still in flight);
  - flush_i has priority over accept.
- Arithmetic: pc+imm is modulo 2**XLEN with wrap-around; the immediate is sign-extended to XLEN.
- Holding: while out_valid_o && !out_ready_i, all out_* are stable.

Optional Feature:
- Macro ID_STAGE_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode, or a funct3 invalid for its class, sets out_illegal_o=1 on that entry; decode is otherwise NOP.
- Undefined: out_illegal_o is tied 0.

Decomposition:
- Shared define header / package:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
  - ALU op and ALU sel encodings, NOP encodings;
  - XLEN/REG_AW defaults.
- One sub-module: id_decoder_comb, a pure inst→fields decoder (aluop, alusel, imm, use_rs1, use_rs2, rd_we, class flags, illegal).
- Scoreboard, forwarding mux and FSM stay in id_stage_hs.

Test Plan:
- Reset mid-stream: rst_n=0 for one cycle with out_valid_o=1 → next cycle out_valid_o=0, redirect_o=0, and a subsequent `lw` use of x5 does not stall.
- Load-use: `lw x5,0(x1)` then `add x6,x5,x7` with out_ready_i=1 → add stalls (in_ready_o=0) until ld_done_i with ld_addr_i=5 and ld_data_i=0x1234; add issues in that same cycle with out_op1_o=0x1234.
- Forward priority: fw[0]=(x3,0xAAAA), fw[1]=(x3,0xBBBB), `addi x4,x3,1` → out_op1_o=0xAAAA, out_op2_o=1.
- x0 guard: fw[0]=(x0,0xDEAD), `add x2,x0,x0` → out_op1_o=out_op2_o=0.
- JAL at pc=0x100 with imm=0x20 → one cycle later redirect_o=1 and redirect_pc_o=0x120; in_ready_o=0 in that cycle, then back to RUN.
- Backpressure plus flush: out_ready_i=0 for 3 cycles → outputs stable; then flush_i=1 → out_valid_o=0 next cycle, and a busy bit set by an earlier load stays set.
